// File: rtl/pulse_gen_if.sv
// Control/status bundle between the CPU-side register block (master) and pulse_gen (slave).
interface pulse_gen_if #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [NUM_W-1:0] pulse_num;
    logic             pulse_out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, high_len, low_len, pulse_num,
        input  pulse_out, busy, done
    );

    modport slave (
        input  start, abort, high_len, low_len, pulse_num,
        output pulse_out, busy, done
    );
endinterface

// File: rtl/pulse_gen.sv
// Programmable pulse-train transmitter: pulse_num pulses of high_len cycles separated by
// low_len-cycle gaps, with busy/done status. All outputs are registered.
module pulse_gen #(
    parameter int   CNT_W      = 16,
    parameter int   NUM_W      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic        clk,
    input logic        rst,
    pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [NUM_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] l_q, l_d;
    logic [NUM_W-1:0] n_q, n_d;
    logic             pulse_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sent_d  = sent_q;
        h_d     = h_q;
        l_d     = l_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    h_d     = (bus.high_len == '0) ? CNT_W'(1) : bus.high_len;
                    l_d     = (bus.low_len == '0) ? CNT_W'(1) : bus.low_len;
                    n_d     = bus.pulse_num;
                    phase_d = CNT_W'(1);
                    sent_d  = '0;
                    state_d = (bus.pulse_num != '0) ? HIGH : DONE;
                end
            end
            HIGH: begin
                if (phase_q == h_q) begin
                    sent_d  = sent_q + NUM_W'(1);
                    phase_d = CNT_W'(1);
                    state_d = (sent_d == n_q) ? DONE : LOW;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            LOW: begin
                if (phase_q == l_q) begin
                    phase_d = CNT_W'(1);
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                phase_d = '0;
                sent_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            phase_d = '0;
            sent_d  = '0;
        end
    end

    // Outputs are derived from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            sent_q  <= '0;
            h_q     <= '0;
            l_q     <= '0;
            n_q     <= '0;
            pulse_q <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sent_q  <= sent_d;
            h_q     <= h_d;
            l_q     <= l_d;
            n_q     <= n_d;
            pulse_q <= IDLE_LEVEL ^ (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_pulse_gen.sv
// Randomized and directed checks of pulse_gen against a cycle-indexed waveform model,
// covering both IDLE_LEVEL polarities driven from identical stimulus.
module tb_pulse_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pulse_gen_if #(.CNT_W(16), .NUM_W(8)) if0 ();
    pulse_gen_if #(.CNT_W(16), .NUM_W(8)) if1 ();

    assign if1.start     = if0.start;
    assign if1.abort     = if0.abort;
    assign if1.high_len  = if0.high_len;
    assign if1.low_len   = if0.low_len;
    assign if1.pulse_num = if0.pulse_num;

    pulse_gen #(.CNT_W(16), .NUM_W(8), .IDLE_LEVEL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    pulse_gen #(.CNT_W(16), .NUM_W(8), .IDLE_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {active, busy, done} for cycle c after a start sampled at edge 0; abort_at<0 means none.
    function automatic logic [2:0] ref_model(int c, int h, int l, int n, int abort_at);
        int  he, le, total;
        logic act, bz, dn;
        he    = (h == 0) ? 1 : h;
        le    = (l == 0) ? 1 : l;
        total = (n == 0) ? 0 : n * he + (n - 1) * le;
        if (abort_at >= 0 && c > abort_at) return 3'b000;
        bz  = (c >= 1) && (c <= total + 1);
        dn  = (c == total + 1);
        act = (c >= 1) && (c <= total) && (((c - 1) % (he + le)) < he);
        return {act, bz, dn};
    endfunction

    function automatic logic [5:0] expand(logic [2:0] e);
        return {e[2], ~e[2], e[1], e[1], e[0], e[0]};
    endfunction

    function automatic logic [5:0] observed();
        return {if0.pulse_out, if1.pulse_out, if0.busy, if1.busy, if0.done, if1.done};
    endfunction

    task automatic set_inputs(logic s, logic a, int h, int l, int n);
        if0.start     = s;
        if0.abort     = a;
        if0.high_len  = 16'(h);
        if0.low_len   = 16'(l);
        if0.pulse_num = 8'(n);
    endtask

    task automatic test_reset();
        logic [5:0] got, want;
        rst = 1'b0;
        set_inputs(1'b1, 1'b0, 3, 2, 2);
        want = expand(3'b000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset i=%0d got=%b want=%b", i, got, want);
            end
        end
        set_inputs(1'b0, 1'b0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        got = observed();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", got, want);
        end
    endtask

    task automatic test_basic();
        logic [5:0] got, want;
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 3, 2, 2);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 3, 2, 2, -1));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL basic c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, 1'b0, 3, 2, 2);
        end
    endtask

    task automatic test_zero();
        logic [5:0] got, want;
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 0, 0, 3);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 0, 0, 3, -1));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL zero_len c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, 1'b0, 0, 0, 0);
        end
        set_inputs(1'b1, 1'b0, 4, 4, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 4, 4, 0, -1));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL zero_num c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    task automatic test_abort();
        logic [5:0] got, want;
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 10, 1, 1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 10, 1, 1, 4));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL abort c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, (c == 4), 10, 1, 1);
        end
        set_inputs(1'b1, 1'b1, 2, 2, 2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 2, 2, 2, 0));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL abort_idle c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, 1'b0, 2, 2, 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, want;
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 5, 3, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 5, 3, 1, -1));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL busy_protect c=%0d got=%b want=%b", c, got, want);
            end
            if (c == 2) set_inputs(1'b1, 1'b0, 1, 1, 4);
            else if (c == 7) set_inputs(1'b1, 1'b0, 2, 1, 2);
            else set_inputs(1'b0, 1'b0, 9, 9, 9);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 2, 1, 2, -1));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL after_done c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got, want;
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 4, 2, 3);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            set_inputs(1'b0, 1'b0, 4, 2, 3);
        end
        #2 rst = 1'b0;
        #1;
        got  = observed();
        want = expand(3'b000);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid got=%b want=%b", got, want);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            got = observed();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_after c=%0d got=%b want=%b", c, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] got, want;
        logic [2:0] e;
        int h, l, n, he, le, total, ab;
        for (int t = 0; t < 30; t++) begin
            h  = $urandom_range(0, 6);
            l  = $urandom_range(0, 6);
            n  = $urandom_range(0, 5);
            he = (h == 0) ? 1 : h;
            le = (l == 0) ? 1 : l;
            total = (n == 0) ? 0 : n * he + (n - 1) * le;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, total + 1) : -1;
            @(negedge clk);
            set_inputs(1'b1, 1'b0, h, l, n);
            for (int c = 1; c <= total + 3; c++) begin
                @(negedge clk);
                got  = observed();
                e    = ref_model(c, h, l, n, ab);
                want = expand(e);
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL random t=%0d h=%0d l=%0d n=%0d ab=%0d c=%0d got=%b want=%b",
                             t, h, l, n, ab, c, got, want);
                end
                if (e[1])
                    set_inputs(1'($urandom_range(0, 1)), (c == ab), $urandom_range(0, 20),
                               $urandom_range(0, 20), $urandom_range(0, 20));
                else
                    set_inputs(1'b0, 1'b0, 0, 0, 0);
            end
        end
    endtask

    task automatic test_max();
        logic [5:0] got, want;
        int l;
        l = $urandom_range(0, 5);
        @(negedge clk);
        set_inputs(1'b1, 1'b0, 65535, l, 1);
        for (int c = 1; c <= 65538; c++) begin
            @(negedge clk);
            got  = observed();
            want = expand(ref_model(c, 65535, l, 1, -1));
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL max_len c=%0d got=%b want=%b", c, got, want);
            end
            set_inputs(1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        set_inputs(1'b0, 1'b0, 0, 0, 0);
        test_reset();
        test_basic();
        test_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
